// File: rtl/wrap_monitor_pkg.sv
// rtl/wrap_monitor_pkg.sv - shared types and constants for the wrap monitor
package wrap_monitor_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_HOLD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    JUMP = 2'd3
  } step_e;

endpackage

// File: rtl/wrap_step_cls.sv
// rtl/wrap_step_cls.sv - classifies one counter step from previous and current sample
module wrap_step_cls
  import wrap_monitor_pkg::*;
(
  input  logic [CNT_W-1:0] prev,
  input  logic [CNT_W-1:0] cur,
  output step_e            cls
);

  logic [CNT_W-1:0] delta;

  // Modular difference: +1 is an up step, -1 (all ones) a down step
  always_comb begin
    delta = cur - prev;
    if (delta == '0) begin
      cls = HOLD;
    end else if (delta == CNT_W'(1)) begin
      cls = UP;
    end else if (delta == '1) begin
      cls = DOWN;
    end else begin
      cls = JUMP;
    end
  end

endmodule

// File: rtl/wrap_monitor.sv
// rtl/wrap_monitor.sv - tracks a 4-bit up/down counter and reports wraps and illegal jumps
module wrap_monitor
  import wrap_monitor_pkg::*;
#(
  parameter int WRAP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              clr_i,
  output logic              ovf_o,
  output logic              udf_o,
  output logic              dir_o,
  output logic [WRAP_W-1:0] wraps_o,
  output logic              err_o,
  output logic [2:0]        state_o
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    prev_q;
  step_e               step;
  logic                ovf_q, ovf_d;
  logic                udf_q, udf_d;
  logic                dir_q, dir_d;
  logic                err_q, err_d;
  logic [WRAP_W-1:0]   wraps_q, wraps_d;
  logic                tracking;
  logic                wrap_up;
  logic                wrap_dn;

  wrap_step_cls u_cls (
    .prev (prev_q),
    .cur  (cnt_i),
    .cls  (step)
  );

  // Steps only count while prev_q is meaningful and no error is latched
  assign tracking = (state_q == S_HOLD) || (state_q == S_UP) || (state_q == S_DOWN);
  assign wrap_up  = tracking && (prev_q == '1) && (cnt_i == '0);
  assign wrap_dn  = tracking && (prev_q == '0) && (cnt_i == '1);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: clear dominates, error absorbs, otherwise follow the step class
  always_comb begin
    state_d = state_q;
    if (clr_i) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT: state_d = S_HOLD;
        S_ERR:  state_d = S_ERR;
        S_HOLD, S_UP, S_DOWN: begin
          case (step)
            HOLD:    state_d = S_HOLD;
            UP:      state_d = S_UP;
            DOWN:    state_d = S_DOWN;
            default: state_d = S_ERR;
          endcase
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // Output next values: pulses, direction, saturating wrap count, error flag
  always_comb begin
    ovf_d   = wrap_up && !clr_i;
    udf_d   = wrap_dn && !clr_i;
    dir_d   = dir_q;
    wraps_d = wraps_q;
    err_d   = (state_d == S_ERR);
    if (tracking && !clr_i) begin
      if (step == UP) begin
        dir_d = 1'b1;
      end else if (step == DOWN) begin
        dir_d = 1'b0;
      end
    end
    if (clr_i) begin
      wraps_d = '0;
    end else if ((wrap_up || wrap_dn) && (wraps_q != '1)) begin
      wraps_d = wraps_q + WRAP_W'(1);
    end
  end

  // Output and sample registers; prev_q follows cnt_i on every edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q  <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dir_q   <= 1'b1;
      wraps_q <= '0;
      err_q   <= 1'b0;
    end else begin
      prev_q  <= cnt_i;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      dir_q   <= dir_d;
      wraps_q <= wraps_d;
      err_q   <= err_d;
    end
  end

  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;
  assign dir_o   = dir_q;
  assign wraps_o = wraps_q;
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_wrap_monitor.sv
// tb/tb_wrap_monitor.sv - self-checking bench for wrap_monitor
module tb_wrap_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cnt;
  logic       clr;

  logic       ovf8, udf8, dir8, err8;
  logic [7:0] wraps8;
  logic [2:0] state8;
  logic       ovf2, udf2, dir2, err2;
  logic [1:0] wraps2;
  logic [2:0] state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wrap_monitor #(.WRAP_W(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .cnt_i(cnt), .clr_i(clr),
    .ovf_o(ovf8), .udf_o(udf8), .dir_o(dir8), .wraps_o(wraps8),
    .err_o(err8), .state_o(state8)
  );

  wrap_monitor #(.WRAP_W(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cnt_i(cnt), .clr_i(clr),
    .ovf_o(ovf2), .udf_o(udf2), .dir_o(dir2), .wraps_o(wraps2),
    .err_o(err2), .state_o(state2)
  );

  // Reference model: plain arithmetic on the sampled sequence
  bit m_init, m_err, m_ovf, m_udf, m_dir;
  int m_prev, m_last, m_w8, m_w2;

  task automatic model_reset();
    m_init = 1; m_err = 0; m_ovf = 0; m_udf = 0; m_dir = 1;
    m_prev = 0; m_last = 1; m_w8 = 0; m_w2 = 0;
  endtask

  task automatic model_step(input int c, input bit cl);
    int d;
    m_ovf = 0;
    m_udf = 0;
    if (cl) begin
      m_init = 1; m_err = 0; m_w8 = 0; m_w2 = 0;
    end else if (m_init) begin
      m_init = 0; m_last = 1;
    end else if (!m_err) begin
      d = (c - m_prev + 16) % 16;
      if (d == 0) m_last = 1;
      else if (d == 1) begin m_last = 2; m_dir = 1; end
      else if (d == 15) begin m_last = 3; m_dir = 0; end
      else m_err = 1;
      m_ovf = (m_prev == 15) && (c == 0);
      m_udf = (m_prev == 0) && (c == 15);
      if (m_ovf || m_udf) begin
        if (m_w8 < 255) m_w8++;
        if (m_w2 < 3) m_w2++;
      end
    end
    m_prev = c;
  endtask

  function automatic int m_state();
    return m_init ? 0 : (m_err ? 4 : m_last);
  endfunction

  task automatic drive(input int c, input bit cl);
    cnt = 4'(c);
    clr = cl;
    @(posedge clk);
    model_step(c, cl);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1; cnt = 0; clr = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    checks++; if ({ovf8, udf8, dir8, err8} !== 4'b0010) begin errors++;
      $display("FAIL reset_flags8 got %b want 0010", {ovf8, udf8, dir8, err8}); end
    checks++; if (wraps8 !== 8'd0) begin errors++; $display("FAIL reset_wraps8 got %0d want 0", wraps8); end
    checks++; if (state8 !== 3'd0) begin errors++; $display("FAIL reset_state8 got %0d want 0", state8); end
    checks++; if ({ovf2, udf2, dir2, err2, wraps2, state2} !== 9'b0010_00_000) begin errors++;
      $display("FAIL reset_dut2 got %b want 001000000", {ovf2, udf2, dir2, err2, wraps2, state2}); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_up_wrap();
    int seq[5] = '{13, 14, 15, 0, 1};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 0);
      pulses += ovf8;
      checks++; if (ovf8 !== (i == 3)) begin errors++;
        $display("FAIL up_wrap_ovf step %0d got %b want %b", i, ovf8, (i == 3)); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL up_wrap_pulses got %0d want 1", pulses); end
    checks++; if (wraps8 !== 8'd1) begin errors++; $display("FAIL up_wrap_wraps got %0d want 1", wraps8); end
    checks++; if (dir8 !== 1'b1 || err8 !== 1'b0) begin errors++;
      $display("FAIL up_wrap_dir_err got %b%b want 10", dir8, err8); end
  endtask

  task automatic test_down_wrap();
    int seq[5] = '{2, 1, 0, 15, 14};
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      drive(seq[i], 0);
      pulses += udf8;
      checks++; if (udf8 !== (i == 3)) begin errors++;
        $display("FAIL down_wrap_udf step %0d got %b want %b", i, udf8, (i == 3)); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL down_wrap_pulses got %0d want 1", pulses); end
    checks++; if (wraps8 !== 8'd2) begin errors++; $display("FAIL down_wrap_wraps got %0d want 2", wraps8); end
    checks++; if (dir8 !== 1'b0 || state8 !== 3'd3) begin errors++;
      $display("FAIL down_wrap_dir_state got dir %b state %0d want dir 0 state 3", dir8, state8); end
  endtask

  task automatic test_jump();
    for (int v = 13; v >= 4; v--) drive(v, 0);
    checks++; if (err8 !== 1'b0) begin errors++; $display("FAIL jump_pre_err got %b want 0", err8); end
    drive(9, 0);
    checks++; if (err8 !== 1'b1 || state8 !== 3'd4) begin errors++;
      $display("FAIL jump_err got err %b state %0d want err 1 state 4", err8, state8); end
    drive(15, 0);
    drive(0, 0);
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL jump_no_ovf got %b want 0", ovf8); end
    checks++; if (wraps8 !== 8'd2 || err8 !== 1'b1) begin errors++;
      $display("FAIL jump_frozen got wraps %0d err %b want wraps 2 err 1", wraps8, err8); end
    drive(0, 1);
    checks++; if (err8 !== 1'b0 || wraps8 !== 8'd0 || state8 !== 3'd0) begin errors++;
      $display("FAIL jump_clear got err %b wraps %0d state %0d want 0 0 0", err8, wraps8, state8); end
  endtask

  task automatic test_saturation();
    int want[5] = '{1, 2, 3, 3, 3};
    drive(15, 0);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0);
      checks++; if (wraps2 !== 2'(want[k]) || ovf2 !== 1'b1) begin errors++;
        $display("FAIL sat_wraps2 wrap %0d got %0d ovf %b want %0d ovf 1", k, wraps2, ovf2, want[k]); end
      checks++; if (wraps8 !== 8'(k + 1)) begin errors++;
        $display("FAIL sat_wraps8 wrap %0d got %0d want %0d", k, wraps8, k + 1); end
      for (int v = 1; v < 16; v++) drive(v, 0);
    end
  endtask

  task automatic test_simultaneous();
    int pulses = 0;
    drive(0, 1);
    checks++; if (ovf8 !== 1'b0 || wraps8 !== 8'd0 || state8 !== 3'd0) begin errors++;
      $display("FAIL clr_wins got ovf %b wraps %0d state %0d want 0 0 0", ovf8, wraps8, state8); end
    drive(15, 0);
    for (int i = 0; i < 10; i++) begin
      drive(15, 0);
      pulses += ovf8 + udf8 + ovf2 + udf2;
    end
    checks++; if (pulses != 0 || state8 !== 3'd1) begin errors++;
      $display("FAIL hold15 got pulses %0d state %0d want 0 1", pulses, state8); end
  endtask

  task automatic test_async_reset();
    drive(0, 0);
    for (int w = 0; w < 2; w++) begin
      for (int v = 1; v < 16; v++) drive(v, 0);
      drive(0, 0);
    end
    drive(1, 0);
    checks++; if (wraps8 !== 8'd3 || state8 !== 3'd2) begin errors++;
      $display("FAIL arst_pre got wraps %0d state %0d want 3 2", wraps8, state8); end
    #3 rst_n = 0;
    #1;
    model_reset();
    checks++; if ({ovf8, udf8, dir8, err8, wraps8, state8} !== {4'b0010, 8'd0, 3'd0}) begin errors++;
      $display("FAIL arst_values8 got %b want 001000000000000", {ovf8, udf8, dir8, err8, wraps8, state8}); end
    checks++; if ({ovf2, udf2, dir2, err2, wraps2, state2} !== 9'b0010_00_000) begin errors++;
      $display("FAIL arst_values2 got %b want 001000000", {ovf2, udf2, dir2, err2, wraps2, state2}); end
    rst_n = 1;
    drive(0, 0);
    checks++; if (udf8 !== 1'b0 || state8 !== 3'd1) begin errors++;
      $display("FAIL arst_first_sample got udf %b state %0d want 0 1", udf8, state8); end
    drive(15, 0);
    checks++; if (udf8 !== 1'b1 || wraps8 !== 8'd1) begin errors++;
      $display("FAIL arst_resume got udf %b wraps %0d want 1 1", udf8, wraps8); end
  endtask

  task automatic test_random();
    int c = 7;
    int r;
    bit cl;
    logic [14:0] act8, exp8;
    logic [8:0]  act2, exp2;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        rst_n = 0;
        #1;
        model_reset();
        rst_n = 1;
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40) c = (c + 1) % 16;
        else if (r < 75) c = (c + 15) % 16;
        else if (r < 95) c = c;
        else c = $urandom_range(0, 15);
        cl = ($urandom_range(0, 19) == 0);
        drive(c, cl);
      end
      act8 = {ovf8, udf8, dir8, err8, state8, wraps8};
      exp8 = {m_ovf, m_udf, m_dir, m_err, 3'(m_state()), 8'(m_w8)};
      act2 = {ovf2, udf2, dir2, err2, state2, wraps2};
      exp2 = {m_ovf, m_udf, m_dir, m_err, 3'(m_state()), 2'(m_w2)};
      checks++; if (act8 !== exp8) begin errors++;
        $display("FAIL random8 cycle %0d got %b want %b (ovf udf dir err state wraps)", n, act8, exp8); end
      checks++; if (act2 !== exp2) begin errors++;
        $display("FAIL random2 cycle %0d got %b want %b (ovf udf dir err state wraps)", n, act2, exp2); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_jump();
    test_saturation();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wrap_monitor.md
WRAP_MONITOR -- requirements
Module: wrap_monitor

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, meaning the width of the saturating wrap-event counter.
REQ-002 The block SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port cnt_i  input  4  count value from the upstream 4-bit up/down counter, sampled every clk_i edge.
REQ-005 The block SHALL have port clr_i  input  1  synchronous clear of the wrap count, the error flag and the tracking state.
REQ-006 The block SHALL have port ovf_o  output  1  one-cycle pulse on an up-wrap (15 -> 0).
REQ-007 The block SHALL have port udf_o  output  1  one-cycle pulse on a down-wrap (0 -> 15).
REQ-008 The block SHALL have port dir_o  output  1  direction of the last non-zero step (1 = up, 0 = down).
REQ-009 The block SHALL have port wraps_o  output  WRAP_W  saturating total of up-wraps plus down-wraps.
REQ-010 The block SHALL have port err_o  output  1  sticky flag set on any illegal jump.
REQ-011 The block SHALL have port state_o  output  3  current FSM state encoding, for debug.

Function
REQ-012 The block SHALL hold prev_q, a 4-bit register loaded with cnt_i on every edge, and compute delta = (cnt_i - prev_q) mod 16.
REQ-013 The block SHALL classify each step from delta: 0 = HOLD, 1 = UP, 15 = DOWN, anything else = JUMP.
REQ-014 The FSM states SHALL be S_INIT, S_HOLD, S_UP, S_DOWN and S_ERR.
- S_INIT: the first sample after reset or clear, with no prev_q valid; it goes to S_HOLD unconditionally and classifies nothing.
REQ-015 From S_HOLD, S_UP or S_DOWN, the next state SHALL follow the step class: HOLD -> S_HOLD, UP -> S_UP, DOWN -> S_DOWN, JUMP -> S_ERR.
REQ-016 S_ERR SHALL be absorbing until clr_i.
- In S_ERR, prev_q still tracks cnt_i.
- In S_ERR, no pulses are emitted and wraps_o is frozen.
REQ-017 ovf_o SHALL be 1 for exactly one cycle, in the cycle after an edge where the FSM was not in S_INIT or S_ERR, prev_q == 15 and cnt_i == 0.
REQ-018 udf_o SHALL be 1 for exactly one cycle under the same conditions with prev_q == 0 and cnt_i == 15.
REQ-019 All outputs SHALL be registered, giving a latency of one clk_i cycle from the sampling edge to the visible output.
REQ-020 wraps_o SHALL increment by 1 on each ovf or udf event and SHALL saturate at 2^WRAP_W - 1 without wrapping.
REQ-021 dir_o SHALL update on UP (to 1) and DOWN (to 0) classifications only; HOLD and JUMP leave it unchanged.
REQ-022 err_o SHALL be 1 in every cycle the FSM is in S_ERR and 0 otherwise.
REQ-023 When clr_i is 1 at an edge, the block SHALL:
- go to S_INIT;
- zero wraps_o and err_o;
- suppress ovf_o and udf_o for that edge, even when a wrap coincides (clear wins);
- leave dir_o unchanged;
- still load prev_q.
REQ-024 A held counter SHALL produce no events: cnt_i steady at 15 or 0 for any number of cycles gives no pulse.

Reset
REQ-025 On rst_ni low, the block SHALL immediately, without waiting for a clock edge, force the following values:
- state = S_INIT;
- prev_q = 0;
- ovf_o = 0, udf_o = 0;
- dir_o = 1;
- wraps_o = 0;
- err_o = 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending event, and the first edge after deassertion SHALL be treated as S_INIT.

Structure
REQ-027 Package wrap_monitor_pkg SHALL contain:
- the FSM state enum (3-bit, fixed encodings S_INIT = 0, S_HOLD = 1, S_UP = 2, S_DOWN = 3, S_ERR = 4);
- the step-class enum (HOLD, UP, DOWN, JUMP);
- constant CNT_W = 4.
REQ-028 Step classification SHALL be a separate combinational sub-module named wrap_step_cls (inputs prev and cur, output step class); the FSM and registers SHALL live in wrap_monitor.

Verification
REQ-029 The bench SHALL cover up-wrap: reset, then cnt_i = 13, 14, 15, 0, 1 -> ovf_o pulses once, one cycle after 0 is sampled; wraps_o = 1; dir_o = 1; err_o = 0.
REQ-030 The bench SHALL cover down-wrap: cnt_i = 2, 1, 0, 15, 14 -> udf_o pulses once; wraps_o increments by 1; dir_o = 0.
REQ-031 The bench SHALL cover an illegal jump: cnt_i = 4 then 9 -> err_o = 1 from the next cycle; a subsequent 15 -> 0 gives no ovf_o and wraps_o stays unchanged; clr_i = 1 -> err_o = 0, wraps_o = 0, state_o = S_INIT.
REQ-032 The bench SHALL cover saturation: with WRAP_W = 2, drive 5 up-wraps -> wraps_o reads 1, 2, 3, 3, 3.
REQ-033 The bench SHALL cover simultaneous events: clr_i = 1 on the edge sampling 15 -> 0 -> no ovf_o and wraps_o = 0; also hold cnt_i = 15 for 10 cycles -> no pulses.
REQ-034 The bench SHALL cover asynchronous reset: assert rst_ni low between edges while wraps_o = 3 and the FSM is in S_UP -> all outputs take their reset values before the next edge; after release, the first sample of cnt_i = 0 produces no udf_o.
